// File: rtl/fpu_pkg.sv
// Shared binary32 field widths, bias and the packed float type for the FPU units.
package fpu_pkg;

    localparam int F32_EXP_W = 8;
    localparam int F32_MAN_W = 23;
    localparam int F32_BIAS  = 127;

    typedef struct packed {
        logic                 s;
        logic [F32_EXP_W-1:0] e;
        logic [F32_MAN_W-1:0] m;
    } f32_t;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero count; lz=32 for an all-zero input.
// Log-depth binary search: each level halves the window that still holds the leading one.
module lzc32 (
    input  logic [31:0] a,
    output logic [5:0]  lz
);

    logic [31:0] v;

    always_comb begin
        v  = a;
        lz = 6'd0;
        if (a == 32'd0) begin
            lz = 6'd32;
        end else begin
            if (v[31:16] == 16'd0) begin
                lz[4] = 1'b1;
                v     = v << 16;
            end
            if (v[31:24] == 8'd0) begin
                lz[3] = 1'b1;
                v     = v << 8;
            end
            if (v[31:28] == 4'd0) begin
                lz[2] = 1'b1;
                v     = v << 4;
            end
            if (v[31:30] == 2'd0) begin
                lz[1] = 1'b1;
                v     = v << 2;
            end
            if (!v[31]) begin
                lz[0] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/itof_pipe.sv
// Signed int32 -> binary32 converter, three register stages (latency 3, 1/cycle).
// Valid/ready on both sides; a stage loads when empty or draining, so bubbles collapse.
module itof_pipe
    import fpu_pkg::*;
#(
    parameter int TAG_W     = 5,
    parameter bit ROUND_RNE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      x,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [7:0] EXP_TOP = 8'(F32_BIAS + 31);

    logic             v1, v2, v3;
    logic [TAG_W-1:0] tag1, tag2, tag3;
    logic             s1, s2;
    logic [31:0]      mag1, norm2;
    logic [5:0]       lz1, lz2;
    f32_t             y3;

    logic             ld1, ld2, ld3;
    logic [7:0]       e_raw;
    logic             inc;
    logic [30:0]      sum;
    f32_t             y_nxt;

    assign ld3      = !v3 || out_ready;
    assign ld2      = !v2 || ld3;
    assign ld1      = !v1 || ld2;
    assign in_ready = ld1;

    lzc32 u_lzc (
        .a  (mag1),
        .lz (lz1)
    );

    // Exponent and fraction are added as one field so a rounding carry out of the
    // fraction lands in the exponent; a normalized zero magnitude has bit31 clear.
    always_comb begin
        e_raw = EXP_TOP - {2'b00, lz2};
        inc   = ROUND_RNE ? (norm2[7] & ((|norm2[6:0]) | norm2[8])) : 1'b0;
        sum   = {e_raw, norm2[30:8]} + {30'd0, inc};
        y_nxt = '0;
        if (norm2[31]) begin
            y_nxt.s = s2;
            y_nxt.e = sum[30:23];
            y_nxt.m = sum[22:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            tag1  <= '0;
            tag2  <= '0;
            tag3  <= '0;
            s1    <= 1'b0;
            s2    <= 1'b0;
            mag1  <= '0;
            norm2 <= '0;
            lz2   <= '0;
            y3    <= '0;
        end else begin
            if (ld1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    tag1 <= in_tag;
                    s1   <= x[31];
                    mag1 <= x[31] ? -x : x;
                end
            end
            if (ld2) begin
                v2 <= v1;
                if (v1) begin
                    tag2  <= tag1;
                    s2    <= s1;
                    norm2 <= mag1 << lz1;
                    lz2   <= lz1;
                end
            end
            if (ld3) begin
                v3 <= v2;
                if (v2) begin
                    tag3 <= tag2;
                    y3   <= y_nxt;
                end
            end
        end
    end

    assign out_valid = v3;
    assign out_tag   = tag3;
    assign y         = y3;

endmodule

// File: tb/tb_itof_pipe.sv
// Bench for itof_pipe: an RNE and a truncating instance share one stimulus stream,
// and a queue-based scoreboard checks every result against an arithmetic model.
module tb_itof_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] x, y;
    logic [4:0]  in_tag, out_tag;
    logic        in_ready_t, out_valid_t;
    logic [31:0] y_t;
    logic [4:0]  out_tag_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] y_rne;
        logic [31:0] y_trn;
        logic [4:0]  tag;
        int          cyc;
        bit          lc;
    } exp_t;

    exp_t sbq[$];

    itof_pipe #(.TAG_W(5), .ROUND_RNE(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .out_tag(out_tag)
    );

    itof_pipe #(.TAG_W(5), .ROUND_RNE(1'b0)) dut_t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t), .x(x), .in_tag(in_tag),
        .out_valid(out_valid_t), .out_ready(out_ready), .y(y_t), .out_tag(out_tag_t)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Nearest float of an integer: scale the magnitude to a 24-bit significand and
    // round the discarded remainder against half a unit.
    function automatic logic [31:0] ref_f32(input logic [31:0] xi, input bit rne);
        longint      v, m, q, r, half;
        int          p, sh;
        bit          s;
        logic [31:0] res;
        v = longint'($signed(xi));
        s = (v < 0);
        m = s ? -v : v;
        p = 0;
        res = 32'd0;
        if (m != 0) begin
            for (int i = 0; i < 33; i++) if (m >= (64'sd1 << i)) p = i;
            if (p <= 23) begin
                q = m << (23 - p);
            end else begin
                sh   = p - 23;
                q    = m >> sh;
                r    = m - (q << sh);
                half = 64'sd1 << (sh - 1);
                if (rne && ((r > half) || ((r == half) && q[0]))) q = q + 1;
            end
            if (q == (64'sd1 << 24)) begin
                q = q >> 1;
                p = p + 1;
            end
            res = {s, 8'(p + 127), q[22:0]};
        end
        return res;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Called at posedge+1; drives one cycle, records an accepted operand, returns at next posedge+1.
    task automatic step(input bit v, input logic [31:0] xv, input logic [4:0] tv, input bit orr,
                        input bit lc, input logic [31:0] er, input logic [31:0] et, output bit acc);
        exp_t e;
        in_valid  = v;
        x         = xv;
        in_tag    = tv;
        out_ready = orr;
        @(negedge clk);
        acc = v && in_ready;
        if (acc) begin
            e.y_rne = er;
            e.y_trn = et;
            e.tag   = tv;
            e.cyc   = cyc;
            e.lc    = lc;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 5'd0, 1'b1, 1'b0, 32'd0, 32'd0, a);
    endtask

    task automatic send_dir(input logic [31:0] xv, input logic [4:0] tv, input logic [31:0] er,
                            input logic [31:0] et);
        bit a;
        step(1'b1, xv, tv, 1'b1, 1'b1, er, et, a);
        chk("dir_accept", {31'd0, a}, 32'd1);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 40 && sbq.size() != 0; i++) idle(1);
        chk(nm, sbq.size(), 32'd0);
    endtask

    // Monitor: pops on each output transfer and checks a stalled output holds still.
    bit          stalled = 1'b0;
    logic [31:0] sy;
    logic [4:0]  st;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_y", y, sy);
                chk("stall_tag", {27'd0, out_tag}, {27'd0, st});
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: tag 0x%02h y 0x%08h with empty scoreboard", out_tag, y);
                end else begin
                    e = sbq.pop_front();
                    chk("y_rne", y, e.y_rne);
                    chk("y_trn", y_t, e.y_trn);
                    chk("tag", {27'd0, out_tag}, {27'd0, e.tag});
                    chk("valid_trn", {31'd0, out_valid_t}, 32'd1);
                    if (e.lc) chk("latency", cyc - e.cyc, 32'd3);
                end
            end
            stalled = out_valid && !out_ready;
            sy = y;
            st = out_tag;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          a, pend, vv;
        int          n;
        logic [31:0] xv;
        logic [4:0]  tg;
        logic [31:0] specials [8];
        specials = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF,
                     32'd16777217, 32'd16777219, 32'hFEFFFFFD};

        rst = 1'b1; in_valid = 1'b0; x = 32'd0; in_tag = 5'd0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        send_dir(32'd1,        5'd1, 32'h3F800000, 32'h3F800000);
        send_dir(32'hFFFFFFFF, 5'd2, 32'hBF800000, 32'hBF800000);
        send_dir(32'd0,        5'd3, 32'h00000000, 32'h00000000);
        send_dir(32'h80000000, 5'd4, 32'hCF000000, 32'hCF000000);
        send_dir(32'h7FFFFFFF, 5'd5, 32'h4F000000, 32'h4EFFFFFF);
        send_dir(32'd16777217, 5'd6, 32'h4B800000, 32'h4B800000);
        send_dir(32'd16777219, 5'd7, 32'h4B800002, 32'h4B800001);
        send_dir(-32'sd16777219, 5'd8, 32'hCB800002, 32'hCB800001);
        drain("dir_drain");

        n = 0;
        for (int i = 0; i < 100; i++) begin
            xv = $urandom;
            step(1'b1, xv, 5'(i), 1'b1, 1'b1, ref_f32(xv, 1'b1), ref_f32(xv, 1'b0), a);
            n += int'(a);
        end
        chk("b2b_accepted", n, 32'd100);
        drain("b2b_drain");

        n = 0; tg = 5'd10; xv = $urandom;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, xv, tg, 1'b0, 1'b0, ref_f32(xv, 1'b1), ref_f32(xv, 1'b0), a);
            if (a) begin
                n++;
                tg++;
                xv = $urandom;
            end
        end
        chk("stall_accepted", n, 32'd3);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        drain("stall_drain");

        pend = 1'b0; tg = 5'd0; vv = 1'b0; xv = 32'd0;
        for (int i = 0; i < 400; i++) begin
            if (!pend) begin
                vv = ($urandom % 3) != 0;
                xv = (($urandom % 5) == 0) ? specials[$urandom % 8] : $urandom;
            end
            step(vv, xv, tg, ($urandom % 4) != 0, 1'b0, ref_f32(xv, 1'b1), ref_f32(xv, 1'b0), a);
            pend = vv && !a;
            if (a) tg++;
        end
        drain("rand_drain");

        for (int i = 0; i < 3; i++) begin
            xv = $urandom;
            step(1'b1, xv, 5'h1A + 5'(i), 1'b0, 1'b0, ref_f32(xv, 1'b1), ref_f32(xv, 1'b0), a);
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
        sbq.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send_dir(32'd2, 5'h05, 32'h40000000, 32'h40000000);
        drain("post_rst_drain");
        idle(4);
        chk("final_out_valid", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
